// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator sequencer: default widths,
// reserved opcodes and the FSM state encoding.
package acc_seq_pkg;

    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned OPW_DEF = 3;
    localparam int unsigned CW_DEF  = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_CLR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/acc_seq.sv
// Command sequencer driving an external ALU and accumulator: each command
// runs cnt execute/writeback iterations and ends with a one-cycle done pulse.
module acc_seq
    import acc_seq_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned OPW = OPW_DEF,
    parameter int unsigned CW  = CW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [DW-1:0]  cmd_imm,
    input  logic [CW-1:0]  cmd_cnt,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic           alu_en,
    input  logic [DW-1:0]  alu_ans,
    output logic           acc_we,
    output logic           acc_clr,
    output logic           busy,
    output logic           done,
    output logic [DW-1:0]  res
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  imm_q;
    logic [CW-1:0]  rem_q;
    logic           skip_q;
    logic           cmd_skip;
    logic           hs;

    assign hs       = cmd_valid & cmd_ready;
    assign cmd_skip = (cmd_op == OPW'(OP_CLR)) || (cmd_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            imm_q   <= '0;
            rem_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                op_q   <= cmd_op;
                imm_q  <= cmd_imm;
                rem_q  <= cmd_cnt;
                skip_q <= cmd_skip;
            end else if (state_q == S_WRITE && rem_q != '0) begin
                rem_q <= rem_q - CW'(1);
            end
        end
    end

    // Outputs are forced low while rst is high so nothing leaks during reset,
    // including the cycle before the state register first settles.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        alu_en    = 1'b0;
        acc_we    = 1'b0;
        acc_clr   = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        alu_op    = '0;
        alu_a     = '0;
        res       = '0;
        if (!rst) begin
            busy = (state_q != S_IDLE);
            if (busy) begin
                alu_op = op_q;
                alu_a  = imm_q;
            end
            unique case (state_q)
                S_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) state_d = cmd_skip ? S_DONE : S_EXEC;
                end
                S_EXEC: begin
                    alu_en  = 1'b1;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    acc_we  = 1'b1;
                    state_d = (rem_q <= CW'(1)) ? S_DONE : S_EXEC;
                end
                S_DONE: begin
                    done    = 1'b1;
                    acc_clr = skip_q && (op_q == OPW'(OP_CLR));
                    res     = skip_q ? '0 : alu_ans;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq with a behavioural ALU (a + accumulator) and
// accumulator attached; expected results are hand-computed constants.
module tb_acc_seq;
    import acc_seq_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 3;
    localparam int unsigned CW  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [DW-1:0]  cmd_imm;
    logic [CW-1:0]  cmd_cnt;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_a;
    logic           alu_en;
    logic [DW-1:0]  alu_ans;
    logic           acc_we;
    logic           acc_clr;
    logic           busy;
    logic           done;
    logic [DW-1:0]  res;

    logic [DW-1:0]  acc_m = '0;
    logic [DW-1:0]  ans_m = '0;

    int n_chk  = 0;
    int n_fail = 0;

    acc_seq #(.DW(DW), .OPW(OPW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt),
        .alu_op(alu_op), .alu_a(alu_a), .alu_en(alu_en), .alu_ans(alu_ans),
        .acc_we(acc_we), .acc_clr(acc_clr),
        .busy(busy), .done(done), .res(res)
    );

    always #5 clk = ~clk;

    assign alu_ans = ans_m;

    always @(posedge clk) begin
        if (alu_en) ans_m <= alu_a + acc_m;
        if (acc_clr)     acc_m <= '0;
        else if (acc_we) acc_m <= ans_m;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one command in the next IDLE cycle and checks every cycle up to done.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] imm,
                           input logic [3:0] cnt, input logic [7:0] exp_res, input bit hold);
        bit         skip;
        int         lat;
        logic [3:0] exp_f;
        skip = (op == OP_CLR) || (cnt == 4'd0);
        lat  = skip ? 1 : 2 * int'(cnt) + 1;
        @(negedge clk);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        cmd_cnt   = cnt;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            exp_f[3] = !skip && (k % 2 == 1) && (k < lat);
            exp_f[2] = !skip && (k % 2 == 0);
            exp_f[1] = (k == lat) && (op == OP_CLR);
            exp_f[0] = (k == lat);
            check($sformatf("%s_flags_c%0d", tag, k), 32'({alu_en, acc_we, acc_clr, done}), 32'(exp_f));
            check($sformatf("%s_a_c%0d", tag, k), 32'({alu_op, alu_a}), 32'({op, imm}));
            check($sformatf("%s_busy_c%0d", tag, k), 32'({busy, cmd_ready}), 32'b10);
            if (k == lat) check({tag, "_res"}, 32'(res), 32'(exp_res));
            if (hold) begin
                cmd_op  = 3'b101;
                cmd_imm = 8'hF0 ^ 8'(k);
                cmd_cnt = '1;
            end else begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_imm   = 8'hAA;
        cmd_cnt   = 4'd3;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rst_ctrl_%0d", i), 32'({cmd_ready, busy, alu_en, acc_we, acc_clr, done}), 32'd0);
            check($sformatf("rst_data_%0d", i), 32'({alu_op, alu_a, res}), 32'd0);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1 check("rel_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("rel_idle", 32'({busy, cmd_ready}), 32'b01);

        run_cmd("add1",  OP_ADD, 8'd1, 4'd1,  8'd1,  1'b0);
        run_cmd("clr_a", OP_CLR, 8'd7, 4'd3,  8'd0,  1'b0);
        run_cmd("add5",  OP_ADD, 8'd5, 4'd5,  8'd25, 1'b0);
        run_cmd("cnt0",  OP_ADD, 8'd9, 4'd0,  8'd0,  1'b0);
        run_cmd("hold",  OP_ADD, 8'd2, 4'd2,  8'd29, 1'b1);
        run_cmd("b2b",   OP_ADD, 8'd3, 4'd1,  8'd32, 1'b0);
        run_cmd("clr_b", OP_CLR, 8'd0, 4'd0,  8'd0,  1'b0);
        run_cmd("max",   OP_ADD, 8'd1, 4'd15, 8'd15, 1'b0);
        run_cmd("clr_c", OP_CLR, 8'd0, 4'd1,  8'd0,  1'b0);

        // Abort a cnt=5 command during its third WRITE cycle.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_imm   = 8'd1;
        cmd_cnt   = 4'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_in_write", 32'(acc_we), 32'd1);
        check("abort_acc_pre", 32'(acc_m), 32'd2);
        rst = 1'b1;
        #1 check("abort_we_gated", 32'({acc_we, done}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort_rst_%0d", i), 32'({busy, alu_en, acc_we, acc_clr, done}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'({busy, cmd_ready, done}), 32'b010);
        check("abort_acc_post", 32'(acc_m), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
